// File: rtl/axi_ocp_wr_bridge_pkg.sv
// Shared encodings, FSM state type and default widths for the AXI-to-OCP write bridge.
package axi_ocp_wr_bridge_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 4;
  localparam int DEF_TAG_W  = 3;
  localparam int DEF_LEN_W  = 4;

  localparam logic [2:0] OCP_CMD_IDLE = 3'b000;
  localparam logic [2:0] OCP_CMD_WR   = 3'b001;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_RESP,
    ST_BRSP
  } state_t;

endpackage

// File: rtl/axi_ocp_wr_bridge.sv
// Single-outstanding AXI write burst to OCP write bridge.
// state | meaning
// IDLE  | accept AW; CMD issue OCP WR command; DATA pass W beats through
// RESP  | wait for OCP response; BRSP present AXI B response
module axi_ocp_wr_bridge
  import axi_ocp_wr_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [ID_W-1:0]   axi_awid,
  input  logic [LEN_W-1:0]  axi_awlen,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [ID_W-1:0]   axi_wid,
  input  logic              axi_wlast,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [ID_W-1:0]   axi_bid,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [ADDR_W-1:0] ocp_mAddr,
  output logic [DATA_W-1:0] ocp_mData,
  output logic [2:0]        ocp_mCmd,
  output logic [TAG_W-1:0]  ocp_mTagId,
  output logic [LEN_W:0]    ocp_mBurstLength,
  output logic              ocp_mReqLast,
  output logic              ocp_mDataValid,
  output logic              ocp_mRespAccept,
  input  logic              ocp_sCmdAccept,
  input  logic              ocp_sDataAccept,
  input  logic [1:0]        ocp_sResp
);

  state_t             state_q, state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [ID_W-1:0]    id_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               err_q;
  logic [1:0]         bresp_q;
  logic               is_last;
  logic               beat;
  logic               aw_hs;

  assign is_last = (cnt_q == len_q);
  assign beat    = (state_q == ST_DATA) && axi_wvalid && ocp_sDataAccept;
  assign aw_hs   = (state_q == ST_IDLE) && axi_awvalid;

  assign ocp_mAddr        = addr_q;
  assign ocp_mTagId       = id_q[TAG_W-1:0];
  assign ocp_mBurstLength = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
  assign axi_bid          = id_q;
  assign axi_bresp        = bresp_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt       = state_q;
    axi_awready     = 1'b0;
    axi_wready      = 1'b0;
    axi_bvalid      = 1'b0;
    ocp_mCmd        = OCP_CMD_IDLE;
    ocp_mData       = '0;
    ocp_mDataValid  = 1'b0;
    ocp_mReqLast    = 1'b0;
    ocp_mRespAccept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // awready must drop while reset is held even though state already reads IDLE
        axi_awready = !rst;
        if (axi_awvalid) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        ocp_mCmd = OCP_CMD_WR;
        if (ocp_sCmdAccept) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        ocp_mDataValid = axi_wvalid;
        ocp_mData      = axi_wdata;
        axi_wready     = ocp_sDataAccept;
        ocp_mReqLast   = is_last;
        if (beat && is_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ocp_mRespAccept = 1'b1;
        if (ocp_sResp != OCP_RESP_NULL) state_nxt = ST_BRSP;
      end
      ST_BRSP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bresp_q <= AXI_RESP_OKAY;
    end else begin
      if (aw_hs) begin
        addr_q <= axi_awaddr;
        id_q   <= axi_awid;
        len_q  <= axi_awlen;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end
      if (beat) begin
        // protocol violations are only flagged; the beat is still forwarded
        if ((axi_wid != id_q) || (axi_wlast != is_last)) err_q <= 1'b1;
        if (!is_last) cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == ST_RESP) && (ocp_sResp != OCP_RESP_NULL)) begin
        if ((ocp_sResp == OCP_RESP_FAIL) || (ocp_sResp == OCP_RESP_ERR) || err_q)
          bresp_q <= AXI_RESP_SLVERR;
        else
          bresp_q <= AXI_RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_ocp_wr_bridge.sv
// Directed bench for axi_ocp_wr_bridge: table of bursts plus hand-written reset sequences.
module tb_axi_ocp_wr_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [3:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wid = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] mAddr;
  logic [31:0] mData;
  logic [2:0]  mCmd;
  logic [2:0]  mTagId;
  logic [4:0]  mBurstLength;
  logic        mReqLast;
  logic        mDataValid;
  logic        mRespAccept;
  logic        sCmdAccept = 1'b0;
  logic        sDataAccept = 1'b0;
  logic [1:0]  sResp = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  axi_ocp_wr_bridge dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(awaddr), .axi_awid(awid), .axi_awlen(awlen),
    .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wid(wid), .axi_wlast(wlast),
    .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .ocp_mAddr(mAddr), .ocp_mData(mData), .ocp_mCmd(mCmd), .ocp_mTagId(mTagId),
    .ocp_mBurstLength(mBurstLength), .ocp_mReqLast(mReqLast),
    .ocp_mDataValid(mDataValid), .ocp_mRespAccept(mRespAccept),
    .ocp_sCmdAccept(sCmdAccept), .ocp_sDataAccept(sDataAccept), .ocp_sResp(sResp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [3:0]  len;
    logic [31:0] addr;
    int          cmd_delay;
    int          bad_wid;
    int          bad_last;
    logic [1:0]  sresp;
    bit          toggle;
    int          bready_delay;
    logic [2:0]  exp_tag;
    logic [4:0]  exp_blen;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int beat;
    bit phase;
    bit first;
    @(negedge clk);
    awvalid = 1'b1; awid = v.id; awlen = v.len; awaddr = v.addr;
    #1 chk("aw_ready", awready, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; sCmdAccept = 1'b0;
    wvalid = 1'b1; wid = v.id; wdata = 32'hDEAD_0000; wlast = 1'b0; sDataAccept = 1'b1;
    #1;
    chk("cmd_wr", mCmd, 3'b001);
    chk("cmd_addr", mAddr, v.addr);
    chk("cmd_tag", mTagId, v.exp_tag);
    chk("cmd_blen", mBurstLength, v.exp_blen);
    chk("early_wready", wready, 0);
    chk("early_dvalid", mDataValid, 0);
    for (int i = 0; i < v.cmd_delay; i++) begin
      @(posedge clk); @(negedge clk);
      #1 chk("cmd_hold", mCmd, 3'b001);
    end
    sCmdAccept = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sCmdAccept = 1'b0;
    beat = 0; phase = 1'b1; first = 1'b1;
    while (beat <= int'(v.len)) begin
      sDataAccept = v.toggle ? phase : 1'b1;
      wid   = (beat == v.bad_wid) ? v.id + 4'd1 : v.id;
      wlast = (beat == v.bad_last) ? !(beat == int'(v.len)) : (beat == int'(v.len));
      wdata = v.addr ^ {8{4'(beat)}};
      #1;
      if (first) chk("data_cmd_idle", mCmd, 3'b000);
      chk("data_valid", mDataValid, 1);
      chk("data_pass", mData, wdata);
      chk("data_wready", wready, sDataAccept);
      chk("data_reqlast", mReqLast, beat == int'(v.len));
      if (sDataAccept) beat++;
      phase = !phase; first = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    sDataAccept = 1'b1; sResp = 2'b00;
    #1;
    chk("resp_no_extra_wready", wready, 0);
    chk("resp_no_dvalid", mDataValid, 0);
    chk("resp_accept", mRespAccept, 1);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    #1 chk("resp_wait_null", mRespAccept, 1);
    sResp = v.sresp;
    @(posedge clk); @(negedge clk);
    sResp = 2'b00; bready = 1'b0;
    for (int i = 0; i < v.bready_delay; i++) begin
      #1;
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_awready", awready, 0);
      @(posedge clk); @(negedge clk);
    end
    bready = 1'b1;
    #1;
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, v.id);
    chk("b_resp", bresp, v.exp_bresp);
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    #1;
    chk("b_done", bvalid, 0);
    chk("idle_awready", awready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         id     len    addr          cd bw  bl  sresp  tg bd tag   blen   bresp
    vecs[0] = '{4'd3,  4'd3,  32'h0000_1000, 1, -1, -1, 2'b01, 0, 0, 3'd3, 5'd4,  2'b00};
    vecs[1] = '{4'd2,  4'd0,  32'h0000_2000, 0, -1, -1, 2'b11, 0, 0, 3'd2, 5'd1,  2'b10};
    vecs[2] = '{4'd5,  4'd3,  32'h0000_3000, 0,  1, -1, 2'b01, 0, 0, 3'd5, 5'd4,  2'b10};
    vecs[3] = '{4'd9,  4'd7,  32'h0000_5000, 2, -1, -1, 2'b01, 1, 5, 3'd1, 5'd8,  2'b00};
    vecs[4] = '{4'd1,  4'd2,  32'h0000_6000, 0, -1,  0, 2'b01, 0, 0, 3'd1, 5'd3,  2'b10};
    vecs[5] = '{4'd15, 4'd15, 32'hFFFF_FFFC, 0, -1, -1, 2'b10, 0, 1, 3'd7, 5'd16, 2'b10};
    vecs[6] = '{4'd4,  4'd1,  32'h0000_7000, 0, -1, -1, 2'b01, 0, 0, 3'd4, 5'd2,  2'b00};

    // reset state with live inputs
    rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; sDataAccept = 1'b1; sResp = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_cmd", mCmd, 3'b000);
    chk("rst_dvalid", mDataValid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_respaccept", mRespAccept, 0);
    chk("rst_reqlast", mReqLast, 0);
    chk("rst_addr", mAddr, 0);
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0; sDataAccept = 1'b0; sResp = 2'b00;
    #1 chk("post_rst_awready", awready, 1);

    foreach (vecs[k]) run_burst(vecs[k]);

    // reset in the middle of a 4-beat burst
    @(negedge clk);
    awvalid = 1'b1; awid = 4'd6; awlen = 4'd3; awaddr = 32'h0000_4000;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; sCmdAccept = 1'b1;
    @(posedge clk); @(negedge clk);
    sCmdAccept = 1'b0; wvalid = 1'b1; wid = 4'd6; wdata = 32'h1111_0000; sDataAccept = 1'b1;
    #1 chk("mid_beat1_valid", mDataValid, 1);
    @(posedge clk); @(negedge clk);
    wdata = 32'h1111_0001; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    #1;
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_dvalid", mDataValid, 0);
    chk("mid_rst_cmd", mCmd, 3'b000);
    chk("mid_rst_reqlast", mReqLast, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_respaccept", mRespAccept, 0);
    chk("mid_rst_addr", mAddr, 0);
    chk("mid_rst_bid", bid, 0);
    chk("mid_rst_blen", mBurstLength, 1);
    rst = 1'b0; wvalid = 1'b0; sDataAccept = 1'b0; sResp = 2'b01; bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_no_bvalid", bvalid, 0);
      chk("mid_idle_awready", awready, 1);
      @(posedge clk); @(negedge clk);
    end
    sResp = 2'b00; bready = 1'b0;
    run_burst(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
